i2s_transmitter: RTL and testbench

//  Output end of the pedal's sample path. Takes processed stereo samples (effect chain

---
 rtl/audio_pkg.sv | 19 +
 rtl/sample_fifo.sv | 57 +++++
 rtl/i2s_transmitter.sv | 157 +++++++++++++++
 tb/tb_i2s_transmitter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and I2S defaults for the pedal output stage.
package audio_pkg;

  localparam int SAMPLE_WIDTH   = 24;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_BCLK_DIV   = 4;
  localparam int I2S_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo pairs. Read data is the head entry whenever empty is low.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH  = I2S_FIFO_DEPTH,
  parameter type item_t = stereo_sample_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  item_t                  wdata,
  input  logic                   pop,
  output item_t                  rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = counter_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  item_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; entries need no reset because the empty flag masks stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: buffers stereo pairs, generates BCLK/LRCLK and shifts
// samples out MSB first, sending silence and flagging underrun when starved.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_WIDTH,
  parameter int SLOT_BITS  = I2S_SLOT_BITS,
  parameter int BCLK_DIV   = I2S_BCLK_DIV,
  parameter int FIFO_DEPTH = I2S_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             s_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int DIV_W = counter_width(BCLK_DIV);
  localparam int BIT_W = counter_width(2 * SLOT_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] WIDTH_C  = BIT_W'(WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } pair_t;

  pair_t            fifo_wdata;
  pair_t            fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_next;
  logic [BIT_W-1:0] slot_bit;
  logic             falling;
  logic             frame_start;
  logic [WIDTH-1:0] left_sr;
  logic [WIDTH-1:0] right_sr;

  assign fifo_wdata  = {s_left, s_right};
  assign push        = s_valid && s_ready && !fifo_full;
  assign falling     = active && (div_cnt == DIV_LAST) && bclk;
  assign bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign slot_bit    = (bit_next >= SLOT_C) ? bit_next - SLOT_C : bit_next;
  assign frame_start = enable && (!active || (falling && (bit_cnt == BIT_LAST)));
  assign pop         = frame_start && !fifo_empty;

  sample_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (pair_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this cycle's push/pop, used to register the ready flag.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CNT_W'(1);
    else if (!push && pop) count_next = fifo_count - CNT_W'(1);
  end

  // Ready is registered so upstream never sees a path from s_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s_ready <= 1'b0;
    else        s_ready <= (count_next != DEPTH_C);
  end

  // Bit clock divider and frame position; everything parks at zero while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
    end else if (!enable) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
    end else if (!active) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bclk    <= !bclk;
      if (bclk) begin
        bit_cnt <= bit_next;
        lrclk   <= (bit_next >= SLOT_C);
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame-start load (or silence on underrun) and MSB-first serialization on falling BCLK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_sr  <= '0;
      right_sr <= '0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && fifo_empty;
      if (!enable) begin
        sdata <= 1'b0;
      end else if (frame_start) begin
        sdata    <= 1'b0;
        left_sr  <= pop ? fifo_rdata.left  : '0;
        right_sr <= pop ? fifo_rdata.right : '0;
      end else if (falling) begin
        if ((slot_bit != '0) && (slot_bit <= WIDTH_C)) begin
          if (bit_next >= SLOT_C) begin
            sdata    <= right_sr[WIDTH-1];
            right_sr <= right_sr << 1;
          end else begin
            sdata   <= left_sr[WIDTH-1];
            left_sr <= left_sr << 1;
          end
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: captures the serial stream at each BCLK rise
// and compares whole frames against a small reference frame builder.
module tb_i2s_transmitter;

  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        enable  = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] s_left  = '0;
  logic [23:0] s_right = '0;
  logic        s_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] bit_q [$];
  int         ur_pulses = 0;
  int         ur_cycles = 0;
  logic       bclk_prev = 1'b0;
  logic       ur_prev   = 1'b0;

  i2s_transmitter #(
    .WIDTH      (24),
    .SLOT_BITS  (32),
    .BCLK_DIV   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_left   (s_left),
    .s_right  (s_right),
    .s_ready  (s_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Record {lrclk, sdata} at every BCLK rise and tally underrun pulses, just after each edge.
  always @(posedge clk) begin
    #1;
    if (bclk && !bclk_prev) bit_q.push_back({lrclk, sdata});
    if (underrun) ur_cycles++;
    if (underrun && !ur_prev) ur_pulses++;
    bclk_prev = bclk;
    ur_prev   = underrun;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 1; i <= 24; i++) begin
      f[i]      = l[24-i];
      f[32 + i] = r[24-i];
    end
    return f;
  endfunction

  function automatic logic [63:0] frame_bits(input int base, input int sel);
    logic [63:0] f;
    f = 'x;
    for (int k = 0; k < 64; k++)
      if (base + k < bit_q.size()) f[k] = bit_q[base + k][sel];
    return f;
  endfunction

  task automatic wait_bits(input int n, input string tag);
    int c;
    c = 0;
    while (bit_q.size() < n && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check_output(tag, 64'(bit_q.size() >= n), 64'd1);
  endtask

  task automatic apply_stimulus(input logic [23:0] l, input logic [23:0] r);
    int c;
    c = 0;
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    while (!s_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check_output("push_ready", 64'(c < 100), 64'd1);
  endtask

  initial begin
    logic [2:0]  t;
    logic [1:0]  r2;
    logic        r;
    logic [63:0] e;
    logic [63:0] f;
    int          ones;
    logic [23:0] pl [5];
    logic [23:0] pr [5];

    pl[0] = 24'h123456; pr[0] = 24'hABCDEF;
    pl[1] = 24'h000001; pr[1] = 24'h800000;
    pl[2] = 24'hF0F0F0; pr[2] = 24'h0F0F0F;
    pl[3] = 24'h555555; pr[3] = 24'hAAAAAA;
    pl[4] = 24'hFEDCBA; pr[4] = 24'h654321;

    // Reset state and release
    @(negedge clk);
    check_output("reset_outputs", 64'({s_ready, bclk, lrclk, sdata, underrun}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("ready_after_release", 64'(s_ready), 64'd1);

    // 1: single pair, extreme values
    apply_stimulus(24'h800001, 24'h7FFFFF);
    bit_q.delete();
    ur_pulses = 0; ur_cycles = 0;
    enable = 1'b1;
    @(negedge clk); t[2] = bclk;
    @(negedge clk); t[1] = bclk;
    @(negedge clk); t[0] = bclk;
    check_output("t1_bclk_first_rise", 64'(t), 64'd1);
    wait_bits(64, "t1_wait");
    enable = 1'b0;
    @(negedge clk);
    check_output("t1_frame_data", frame_bits(0, 0), exp_frame(24'h800001, 24'h7FFFFF));
    check_output("t1_lrclk", frame_bits(0, 1), LR_EXP);
    check_output("t1_underruns", 64'(ur_pulses), 64'd0);

    // 2: starved for three frames
    bit_q.delete();
    ur_pulses = 0; ur_cycles = 0;
    enable = 1'b1;
    wait_bits(192, "t2_wait");
    enable = 1'b0;
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 192; k++) if (bit_q[k][0] !== 1'b0) ones++;
    check_output("t2_silence", 64'(ones), 64'd0);
    check_output("t2_lrclk", frame_bits(64, 1), LR_EXP);
    check_output("t2_underrun_pulses", 64'(ur_pulses), 64'd3);
    check_output("t2_underrun_cycles", 64'(ur_cycles), 64'd3);

    // 3: fill while disabled, fifth pair held until the first pop
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_left  = pl[i];
      s_right = pr[i];
      @(negedge clk);
    end
    s_left  = pl[4];
    s_right = pr[4];
    r2[1] = s_ready;
    @(negedge clk);
    @(negedge clk);
    r2[0] = s_ready;
    check_output("t3_ready_full", 64'(r2), 64'd0);
    bit_q.delete();
    ur_pulses = 0; ur_cycles = 0;
    enable = 1'b1;
    t[2] = s_ready;
    @(negedge clk); t[1] = s_ready;
    @(negedge clk); t[0] = s_ready;
    s_valid = 1'b0;
    check_output("t3_fifth_handshake", 64'(t), 64'd2);
    wait_bits(320, "t3_wait");
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("t3_frame%0d", i + 1), frame_bits(64 * i, 0), exp_frame(pl[i], pr[i]));
    check_output("t3_underruns", 64'(ur_pulses), 64'd0);

    // 4: reset in the middle of a loaded frame
    apply_stimulus(24'hFFFFFF, 24'h000000);
    apply_stimulus(24'h123123, 24'h321321);
    bit_q.delete();
    enable = 1'b1;
    wait_bits(11, "t4_wait");
    f = frame_bits(0, 0);
    check_output("t4_prefix", 64'(f[10:0]), 64'h7FE);
    reset = 1'b0;
    #1;
    check_output("t4_reset_outputs", 64'({bclk, lrclk, sdata, s_ready, underrun}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    ur_pulses = 0; ur_cycles = 0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_output("t4_underrun_after_release", 64'(ur_pulses), 64'd1);
    enable = 1'b0;
    @(negedge clk);

    // 5: enable glitch mid-frame with two pairs queued
    apply_stimulus(24'hA5A5A5, 24'h5A5A5A);
    apply_stimulus(24'hC3C3C3, 24'h3C3C3C);
    bit_q.delete();
    enable = 1'b1;
    wait_bits(41, "t5_wait_a");
    e = exp_frame(24'hA5A5A5, 24'h5A5A5A);
    f = frame_bits(0, 0);
    check_output("t5_prefix_a", 64'(f[40:0]), 64'(e[40:0]));
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    bit_q.delete();
    ur_pulses = 0; ur_cycles = 0;
    wait_bits(64, "t5_wait_b");
    enable = 1'b0;
    @(negedge clk);
    check_output("t5_frame_b", frame_bits(0, 0), exp_frame(24'hC3C3C3, 24'h3C3C3C));
    check_output("t5_lrclk", frame_bits(0, 1), LR_EXP);
    check_output("t5_underruns", 64'(ur_pulses), 64'd0);

    // 6: push coincident with the frame-start pop at count 1
    apply_stimulus(24'h0BEEF0, 24'h0CAFE0);
    s_valid = 1'b1;
    s_left  = 24'h7A5A5A;
    s_right = 24'h81818F;
    bit_q.delete();
    ur_pulses = 0; ur_cycles = 0;
    enable = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    r = s_ready;
    check_output("t6_ready_after_pushpop", 64'(r), 64'd1);
    wait_bits(128, "t6_wait");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_output("t6_frame_c", frame_bits(0, 0), exp_frame(24'h0BEEF0, 24'h0CAFE0));
    check_output("t6_frame_d", frame_bits(64, 0), exp_frame(24'h7A5A5A, 24'h81818F));
    check_output("t6_underrun_third", 64'(ur_pulses), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
